// File: rtl/cache_line_fill_mem_if.sv
// Cache <-> backing-memory bus: line-fill request, response burst, write-through store.
interface cache_line_fill_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_line;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_beat;
  logic        rsp_last;
  logic [31:0] rsp_line;
  logic        wr_valid;
  logic        wr_ready;
  logic [34:0] wr_addr;
  logic [31:0] wr_data;

  // Cache side
  modport master (
    output req_valid, req_line, rsp_ready, wr_valid, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_line, wr_ready
  );

  // Memory side
  modport slave (
    input  req_valid, req_line, rsp_ready, wr_valid, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_line, wr_ready
  );
endinterface

// File: rtl/cache_line_fill_mem.sv
// Backing memory behind the direct-mapped cache: serves 8-word line refills
// after a fixed access latency and absorbs single-word write-through stores.
module cache_line_fill_mem #(
  parameter int LATENCY = 4,
  parameter int LINE_AW = 6
) (
  input logic                 clk,
  input logic                 rst,
  cache_line_fill_mem_if.slave bus
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MW = LINE_AW + 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_valid;
  logic [2:0]  r_beat;
  logic [31:0] r_data;
  logic [31:0] r_line;
  logic [31:0] r_mem [2**MW];

  logic w_req_ready, w_wr_ready;
  logic w_req_hs, w_wr_hs, w_rsp_hs;
  logic [2:0] w_beat_nxt;
  logic w_unused;

  assign w_req_hs   = bus.req_valid && w_req_ready;
  assign w_wr_hs    = bus.wr_valid && w_wr_ready;
  assign w_rsp_hs   = r_valid && bus.rsp_ready;
  assign w_beat_nxt = r_beat + 3'd1;
  // Tag bits above the stored index are dropped: lines alias modulo 2^LINE_AW.
  assign w_unused   = &{1'b0, bus.wr_addr[34:MW]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_BURST;
      S_BURST: if (w_rsp_hs && r_beat == 3'd7) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ready outputs: only IDLE takes traffic, and a store beats a same-cycle request
  always_comb begin
    w_req_ready = 1'b0;
    w_wr_ready  = 1'b0;
    if (!rst && r_state == S_IDLE) begin
      w_wr_ready  = 1'b1;
      w_req_ready = !bus.wr_valid;
    end
  end

  // Latency counter, line capture and beat sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_beat  <= 3'd0;
      r_data  <= 32'd0;
      r_line  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req_hs) begin
          r_line <= bus.req_line;
          r_cnt  <= CW'(LATENCY - 1);
        end
        S_WAIT: if (r_cnt == '0) begin
          r_valid <= 1'b1;
          r_beat  <= 3'd0;
          r_data  <= r_mem[{r_line[LINE_AW-1:0], 3'd0}];
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_BURST: if (w_rsp_hs) begin
          if (r_beat == 3'd7) begin
            r_valid <= 1'b0;
          end else begin
            r_beat <= w_beat_nxt;
            r_data <= r_mem[{r_line[LINE_AW-1:0], w_beat_nxt}];
          end
        end
        default: ;
      endcase
    end
  end

  // Store array: written on store handshake, never reset
  always_ff @(posedge clk) begin
    if (w_wr_hs) r_mem[bus.wr_addr[MW-1:0]] <= bus.wr_data;
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.rsp_valid = r_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_beat  = r_beat;
  assign bus.rsp_last  = r_valid && (r_beat == 3'd7);
  assign bus.rsp_line  = r_line;
endmodule

// File: tb/tb_cache_line_fill_mem.sv
// Scoreboard bench: stimulus pushes expected beats, per-instance monitors pop and compare.
module tb_cache_line_fill_mem;
  logic clk, rst;

  typedef struct packed {
    logic [31:0] line;
    logic [2:0]  beat;
    logic [31:0] data;
    logic        last;
  } exp_t;

  cache_line_fill_mem_if if0 ();
  cache_line_fill_mem_if if1 ();

  cache_line_fill_mem #(.LATENCY(4), .LINE_AW(6)) u0 (.clk(clk), .rst(rst), .bus(if0));
  cache_line_fill_mem #(.LATENCY(1), .LINE_AW(6)) u1 (.clk(clk), .rst(rst), .bus(if1));

  // Per-instance drive/observe arrays (index 0: LATENCY=4, index 1: LATENCY=1)
  logic        tb_req_valid [2];
  logic [31:0] tb_req_line  [2];
  logic        tb_rsp_ready [2];
  logic        tb_wr_valid  [2];
  logic [34:0] tb_wr_addr   [2];
  logic [31:0] tb_wr_data   [2];
  logic        o_req_ready  [2];
  logic        o_wr_ready   [2];
  logic        o_rsp_valid  [2];
  logic [31:0] o_rsp_data   [2];
  logic [2:0]  o_rsp_beat   [2];
  logic        o_rsp_last   [2];
  logic [31:0] o_rsp_line   [2];

  assign if0.req_valid = tb_req_valid[0];  assign if1.req_valid = tb_req_valid[1];
  assign if0.req_line  = tb_req_line[0];   assign if1.req_line  = tb_req_line[1];
  assign if0.rsp_ready = tb_rsp_ready[0];  assign if1.rsp_ready = tb_rsp_ready[1];
  assign if0.wr_valid  = tb_wr_valid[0];   assign if1.wr_valid  = tb_wr_valid[1];
  assign if0.wr_addr   = tb_wr_addr[0];    assign if1.wr_addr   = tb_wr_addr[1];
  assign if0.wr_data   = tb_wr_data[0];    assign if1.wr_data   = tb_wr_data[1];
  assign o_req_ready[0] = if0.req_ready;   assign o_req_ready[1] = if1.req_ready;
  assign o_wr_ready[0]  = if0.wr_ready;    assign o_wr_ready[1]  = if1.wr_ready;
  assign o_rsp_valid[0] = if0.rsp_valid;   assign o_rsp_valid[1] = if1.rsp_valid;
  assign o_rsp_data[0]  = if0.rsp_data;    assign o_rsp_data[1]  = if1.rsp_data;
  assign o_rsp_beat[0]  = if0.rsp_beat;    assign o_rsp_beat[1]  = if1.rsp_beat;
  assign o_rsp_last[0]  = if0.rsp_last;    assign o_rsp_last[1]  = if1.rsp_last;
  assign o_rsp_line[0]  = if0.rsp_line;    assign o_rsp_line[1]  = if1.rsp_line;

  int   tests = 0, fails = 0;
  exp_t q [2][$];
  int   lat [2] = '{4, 1};
  time  acc_t [2];
  logic pend [2];
  logic pv [2], pr [2];
  logic [31:0] pd [2];
  logic [2:0]  pb [2];
  int   hs [2];
  logic [31:0] ew [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: stall stability, first-beat latency and in-order beat contents
  task automatic mon(input int id);
    exp_t e;
    logic v, r;
    v = o_rsp_valid[id];
    r = tb_rsp_ready[id];
    if (rst) begin
      pv[id] = 1'b0; pr[id] = 1'b0; pend[id] = 1'b0;
      return;
    end
    if (pv[id] && !pr[id] && v)
      chk($sformatf("stall_hold%0d", id), {33'd0, pb[id], o_rsp_data[id]}, {33'd0, o_rsp_beat[id], pd[id]});
    if (v && !pv[id] && pend[id]) begin
      chk($sformatf("latency%0d", id), 68'($time - acc_t[id]), 68'(lat[id] * 10 + 5));
      pend[id] = 1'b0;
    end
    if (v && r) begin
      hs[id]++;
      if (q[id].size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat%0d: got beat %0d data %h expected none", id, o_rsp_beat[id], o_rsp_data[id]);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("beat%0d_%0d", id, e.beat),
            {o_rsp_line[id], o_rsp_beat[id], o_rsp_data[id], o_rsp_last[id]}, e);
      end
    end
    pv[id] = v; pr[id] = r; pd[id] = o_rsp_data[id]; pb[id] = o_rsp_beat[id];
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  // Drive one store and hold until accepted
  task automatic do_wr(input int id, input logic [34:0] a, input logic [31:0] d);
    int n = 0;
    tb_wr_valid[id] = 1'b1; tb_wr_addr[id] = a; tb_wr_data[id] = d;
    @(negedge clk);
    while (!o_wr_ready[id] && n < 20) begin @(negedge clk); n++; end
    if (!o_wr_ready[id]) begin tests++; fails++; $display("FAIL wr_timeout%0d: got no wr_ready expected 1", id); end
    @(posedge clk); #1 tb_wr_valid[id] = 1'b0;
  endtask

  // Push the expected burst (words in ew) and issue the request
  task automatic push_exp(input int id, input logic [31:0] line);
    exp_t e;
    acc_t[id] = $time; pend[id] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.line = line; e.beat = 3'(k); e.data = ew[k]; e.last = (k == 7);
      q[id].push_back(e);
    end
  endtask

  task automatic do_req(input int id, input logic [31:0] line);
    int n = 0;
    tb_req_valid[id] = 1'b1; tb_req_line[id] = line;
    @(negedge clk);
    while (!o_req_ready[id] && n < 20) begin @(negedge clk); n++; end
    if (!o_req_ready[id]) begin tests++; fails++; $display("FAIL req_timeout%0d: got no req_ready expected 1", id); end
    @(posedge clk);
    push_exp(id, line);
    #1 tb_req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    @(negedge clk);
    while ((q[id].size() != 0 || o_rsp_valid[id]) && n < 200) begin @(negedge clk); n++; end
    if (q[id].size() != 0 || o_rsp_valid[id]) begin
      tests++; fails++; $display("FAIL burst_timeout%0d: got %0d beats left expected 0", id, q[id].size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, h0;
    for (int i = 0; i < 2; i++) begin
      tb_req_valid[i] = 0; tb_req_line[i] = 0; tb_rsp_ready[i] = 0;
      tb_wr_valid[i] = 0; tb_wr_addr[i] = 0; tb_wr_data[i] = 0;
      pend[i] = 0; pv[i] = 0; pr[i] = 0; pd[i] = 0; pb[i] = 0; hs[i] = 0; acc_t[i] = 0;
    end

    // Reset with a request pending: nothing accepted, nothing returned
    rst = 1'b1; tb_req_valid[0] = 1'b1; tb_req_line[0] = 32'h12345678;
    @(posedge clk); @(negedge clk);
    chk("rst_rsp_valid_c1", 68'(o_rsp_valid[0]), 68'd0);
    chk("rst_req_ready_c1", 68'(o_req_ready[0]), 68'd0);
    @(negedge clk);
    chk("rst_rsp_valid_c2", 68'(o_rsp_valid[0]), 68'd0);
    tb_req_valid[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    tb_rsp_ready[0] = 1'b1; tb_rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 68'(o_req_ready[0]), 68'd1);
    chk("idle_wr_ready",  68'(o_wr_ready[0]),  68'd1);
    chk("rst_rsp_state",  {o_rsp_line[0], o_rsp_beat[0], o_rsp_data[0], o_rsp_last[0]}, 68'd0);
    @(posedge clk); #1;

    // Preload line 0xFFFFFF00 and fill with rsp_ready held high
    for (int k = 0; k < 8; k++) do_wr(0, {24'hFFFFFF, 8'h00, 3'(k)}, 32'hA0000000 + k);
    for (int k = 0; k < 8; k++) ew[k] = 32'hA0000000 + k;
    do_req(0, 32'hFFFFFF00);
    wait_done(0);

    // Same fill under back-pressure: rsp_ready pattern 1,0,0 repeating
    h0 = hs[0];
    do_req(0, 32'hFFFFFF00);
    n = 0;
    while ((q[0].size() != 0 || o_rsp_valid[0]) && n < 100) begin
      tb_rsp_ready[0] = (n % 3 == 0);
      @(posedge clk); #1; n++;
    end
    tb_rsp_ready[0] = 1'b1;
    wait_done(0);
    chk("bp_handshakes", 68'(hs[0] - h0), 68'd8);

    // Store and request in the same IDLE cycle: store first, request next cycle
    for (int k = 0; k < 8; k++) do_wr(0, {24'h111111, 8'h01, 3'(k)}, 32'hB0000000 + k);
    tb_wr_valid[0] = 1'b1; tb_wr_addr[0] = {24'h111111, 8'h01, 3'd1}; tb_wr_data[0] = 32'h1;
    tb_req_valid[0] = 1'b1; tb_req_line[0] = 32'h11111101;
    @(negedge clk);
    chk("sim_wr_ready",  68'(o_wr_ready[0]),  68'd1);
    chk("sim_req_block", 68'(o_req_ready[0]), 68'd0);
    @(posedge clk); #1 tb_wr_valid[0] = 1'b0;
    @(negedge clk);
    chk("sim_req_next", 68'(o_req_ready[0]), 68'd1);
    for (int k = 0; k < 8; k++) ew[k] = 32'hB0000000 + k;
    ew[1] = 32'h00000001;
    @(posedge clk);
    push_exp(0, 32'h11111101);
    #1 tb_req_valid[0] = 1'b0;
    wait_done(0);

    // Reset after beat 3 has been consumed
    for (int k = 0; k < 8; k++) ew[k] = 32'hA0000000 + k;
    do_req(0, 32'hFFFFFF00);
    n = 0;
    @(negedge clk);
    while (!(o_rsp_valid[0] && o_rsp_beat[0] == 3'd3) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL beat3_timeout: got no beat 3 expected beat 3"); end
    @(posedge clk); #1 rst = 1'b1; tb_rsp_ready[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0; tb_rsp_ready[0] = 1'b1;
    q[0].delete();
    @(negedge clk);
    chk("mid_rst_valid", 68'(o_rsp_valid[0]), 68'd0);
    chk("mid_rst_idle",  68'(o_req_ready[0]), 68'd1);
    @(posedge clk); #1;
    do_req(0, 32'hFFFFFF00);
    wait_done(0);

    // LATENCY=1 instance: line 0x40 aliases line 0x00
    for (int k = 0; k < 8; k++) do_wr(1, {24'h000000, 8'h00, 3'(k)}, 32'hC0000000 + k);
    for (int k = 0; k < 8; k++) ew[k] = 32'hC0000000 + k;
    do_req(1, 32'h00000040);
    wait_done(1);

    chk("q0_empty", 68'(q[0].size()), 68'd0);
    chk("q1_empty", 68'(q[1].size()), 68'd0);
    chk("hs1_total", 68'(hs[1]), 68'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
